dm_arbiter: RTL and testbench

//  Shares the single-port data memory (DM) between two requesters: the core load/store unit (core_*)
//  and a DMA/debug port (dma_*). Arbitrates, latches the winning request, drives the DM for one

---
 rtl/dm_arbiter_pkg.sv | 25 ++
 rtl/dm_addr_check.sv | 30 +++
 rtl/dm_arbiter.sv | 138 +++++++++++++
 tb/tb_dm_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arbiter_pkg.sv
// Purpose: shared definitions for the data-memory arbiter (region map, FSM and requester encodings).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: STATIC/HEAP/STACK window bounds (inclusive), state_e, req_id_e.
package dm_arbiter_pkg;

  // Mapped data-memory windows, bounds inclusive. The gaps between them are unmapped.
  localparam logic [31:0] STATIC_BEGIN = 32'h0000_0000;
  localparam logic [31:0] STATIC_END   = 32'h0000_0FFF;
  localparam logic [31:0] HEAP_BEGIN   = 32'h0000_2000;
  localparam logic [31:0] HEAP_END     = 32'h0000_2FFF;
  localparam logic [31:0] STACK_BEGIN  = 32'h0000_F000;
  localparam logic [31:0] STACK_END    = 32'h0000_FFFF;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  typedef enum logic {
    ID_CORE = 1'b0,
    ID_DMA  = 1'b1
  } req_id_e;

endpackage

// File: rtl/dm_addr_check.sv
// Purpose: classify a data-memory byte address as misaligned and/or outside every mapped window.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: addr (byte address in) -> misaligned (addr[1:0]!=0), unmapped (no window hit), err (either).
module dm_addr_check
  import dm_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              misaligned,
  output logic              unmapped,
  output logic              err
);

  function automatic logic in_win(input logic [ADDR_W-1:0] a,
                                  input logic [ADDR_W-1:0] lo,
                                  input logic [ADDR_W-1:0] hi);
    return (a >= lo) && (a <= hi);
  endfunction

  always_comb begin
    misaligned = |addr[1:0];
    unmapped   = !(in_win(addr, ADDR_W'(STATIC_BEGIN), ADDR_W'(STATIC_END)) ||
                   in_win(addr, ADDR_W'(HEAP_BEGIN),   ADDR_W'(HEAP_END))   ||
                   in_win(addr, ADDR_W'(STACK_BEGIN),  ADDR_W'(STACK_END)));
    err        = misaligned | unmapped;
  end

endmodule

// File: rtl/dm_arbiter.sv
// Purpose: share the single-port data memory between the core LSU and the DMA/debug port.
// Latency: request sampled in IDLE (N), gnt + DM access in N+1, registered rvalid/rd/err in N+2.
// Backpressure: requester holds req until its gnt; the loser of a tie waits for the next IDLE.
// Ports: core_* / dma_* request+response pairs, dm_addr_o/dm_wd_o/dm_we_o to DM, dm_rd_i from DM.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter bit CORE_PRIO = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  // core load/store unit
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wd_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [DATA_W-1:0] core_rd_o,
  output logic              core_err_o,
  // DMA / debug port
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_wd_i,
  output logic              dma_gnt_o,
  output logic              dma_rvalid_o,
  output logic [DATA_W-1:0] dma_rd_o,
  output logic              dma_err_o,
  // data memory
  output logic [ADDR_W-1:0] dm_addr_o,
  output logic [DATA_W-1:0] dm_wd_o,
  output logic              dm_we_o,
  input  logic [DATA_W-1:0] dm_rd_i
);

  state_e            state_q;
  req_id_e           owner_q;
  req_id_e           rr_last_q;
  req_id_e           win;
  logic              lat_we_q;
  logic [ADDR_W-1:0] lat_addr_q;
  logic [DATA_W-1:0] lat_wd_q;
  logic              chk_mis;
  logic              chk_unm;
  logic              chk_err;
  logic              acc_err;
  logic              in_access;
  logic [DATA_W-1:0] acc_rd;

  // Only the latched address is checked, so the live request bus never reaches the DM path.
  dm_addr_check #(
    .ADDR_W (ADDR_W)
  ) u_addr_check (
    .addr       (lat_addr_q),
    .misaligned (chk_mis),
    .unmapped   (chk_unm),
    .err        (chk_err)
  );

  // Either cause on its own is enough to block the access.
  assign acc_err   = chk_err | chk_mis | chk_unm;
  assign in_access = (state_q == ST_ACCESS);
  assign acc_rd    = (lat_we_q || acc_err) ? '0 : dm_rd_i;

  // Tie-break: fixed core priority, or alternate away from the last winner.
  always_comb begin
    win = ID_CORE;
    if (core_req_i && dma_req_i) begin
      if (CORE_PRIO) win = ID_CORE;
      else           win = (rr_last_q == ID_CORE) ? ID_DMA : ID_CORE;
    end else if (dma_req_i) begin
      win = ID_DMA;
    end
  end

  // Decoded from registered state only; an async reset in ACCESS drops dm_we_o at once.
  assign core_gnt_o = in_access && (owner_q == ID_CORE);
  assign dma_gnt_o  = in_access && (owner_q == ID_DMA);
  assign dm_we_o    = in_access && lat_we_q && !acc_err;
  assign dm_addr_o  = lat_addr_q;
  assign dm_wd_o    = lat_wd_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_IDLE;
      owner_q       <= ID_CORE;
      rr_last_q     <= ID_DMA;
      lat_we_q      <= 1'b0;
      lat_addr_q    <= '0;
      lat_wd_q      <= '0;
      core_rvalid_o <= 1'b0;
      core_rd_o     <= '0;
      core_err_o    <= 1'b0;
      dma_rvalid_o  <= 1'b0;
      dma_rd_o      <= '0;
      dma_err_o     <= 1'b0;
    end else begin
      core_rvalid_o <= 1'b0;
      dma_rvalid_o  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (core_req_i || dma_req_i) begin
            state_q   <= ST_ACCESS;
            owner_q   <= win;
            rr_last_q <= win;
            if (win == ID_CORE) begin
              lat_we_q   <= core_we_i;
              lat_addr_q <= core_addr_i;
              lat_wd_q   <= core_wd_i;
            end else begin
              lat_we_q   <= dma_we_i;
              lat_addr_q <= dma_addr_i;
              lat_wd_q   <= dma_wd_i;
            end
          end
        end
        ST_ACCESS: begin
          state_q <= ST_IDLE;
          // rd/err hold until the owner's next response; only rvalid pulses.
          if (owner_q == ID_CORE) begin
            core_rvalid_o <= 1'b1;
            core_rd_o     <= acc_rd;
            core_err_o    <= acc_err;
          end else begin
            dma_rvalid_o  <= 1'b1;
            dma_rd_o      <= acc_rd;
            dma_err_o     <= acc_err;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Purpose: self-checking bench for dm_arbiter: transaction-level scoreboard plus directed literals.
// Latency: n/a.
// Backpressure: requesters hold req until gnt, as the protocol requires.
module tb_dm_arbiter;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  logic rst_n_i;

  // main DUT, round-robin mode
  logic        core_req, core_we, dma_req, dma_we;
  logic [31:0] core_addr, core_wd, dma_addr, dma_wd;
  logic        core_gnt_o, core_rvalid_o, core_err_o, dma_gnt_o, dma_rvalid_o, dma_err_o;
  logic [31:0] core_rd_o, dma_rd_o, dm_addr_o, dm_wd_o, dm_rd;
  logic        dm_we_o;

  // second DUT, fixed core priority
  logic        p_core_req, p_core_we, p_dma_req, p_dma_we;
  logic [31:0] p_core_addr, p_core_wd, p_dma_addr, p_dma_wd;
  logic        p_core_gnt, p_core_rvalid, p_core_err, p_dma_gnt, p_dma_rvalid, p_dma_err;
  logic [31:0] p_core_rd, p_dma_rd, p_dm_addr, p_dm_wd;
  logic [31:0] p_dm_rd = 32'hCAFE_F00D;
  logic        p_dm_we;

  dm_arbiter #(.ADDR_W(32), .DATA_W(32), .CORE_PRIO(1'b0)) u_dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr), .core_wd_i(core_wd),
    .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o), .core_rd_o(core_rd_o), .core_err_o(core_err_o),
    .dma_req_i(dma_req), .dma_we_i(dma_we), .dma_addr_i(dma_addr), .dma_wd_i(dma_wd),
    .dma_gnt_o(dma_gnt_o), .dma_rvalid_o(dma_rvalid_o), .dma_rd_o(dma_rd_o), .dma_err_o(dma_err_o),
    .dm_addr_o(dm_addr_o), .dm_wd_o(dm_wd_o), .dm_we_o(dm_we_o), .dm_rd_i(dm_rd)
  );

  dm_arbiter #(.ADDR_W(32), .DATA_W(32), .CORE_PRIO(1'b1)) u_prio (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .core_req_i(p_core_req), .core_we_i(p_core_we), .core_addr_i(p_core_addr), .core_wd_i(p_core_wd),
    .core_gnt_o(p_core_gnt), .core_rvalid_o(p_core_rvalid), .core_rd_o(p_core_rd), .core_err_o(p_core_err),
    .dma_req_i(p_dma_req), .dma_we_i(p_dma_we), .dma_addr_i(p_dma_addr), .dma_wd_i(p_dma_wd),
    .dma_gnt_o(p_dma_gnt), .dma_rvalid_o(p_dma_rvalid), .dma_rd_o(p_dma_rd), .dma_err_o(p_dma_err),
    .dm_addr_o(p_dm_addr), .dm_wd_o(p_dm_wd), .dm_we_o(p_dm_we), .dm_rd_i(p_dm_rd)
  );

  // DM model driven by the DUT: combinational read, write on posedge.
  logic [31:0] dm_mem  [0:16383];
  logic [31:0] ref_mem [0:16383];
  assign dm_rd = dm_mem[dm_addr_o[15:2]];
  always @(posedge clk_i) if (dm_we_o) dm_mem[dm_addr_o[15:2]] <= dm_wd_o;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: an access is an event scheduled for the cycle the DM is driven;
  // the response appears the cycle after. Regions written straight from the memory map.
  typedef struct {
    bit          who;   // 0 core, 1 dma
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          err;
  } acc_t;

  acc_t        acc_at [int];
  int          cyc = 0;
  int          next_free = 0;
  bit          last_win = 1'b1;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_wd = 32'h0;

  function automatic bit addr_err(input logic [31:0] a);
    bit mapped;
    mapped = (a <= 32'h0FFF) || (a >= 32'h2000 && a <= 32'h2FFF) || (a >= 32'hF000 && a <= 32'hFFFF);
    return (a[1:0] != 2'b00) || !mapped;
  endfunction

  // observations used by the directed checks
  bit          gnt_log [$];
  int          core_gnt_cyc [$];
  int          we_cnt = 0;
  int          core_rsp_n = 0;
  int          dma_rsp_n = 0;
  logic [31:0] core_last_rd, dma_last_rd;
  logic        core_last_err, dma_last_err;

  always @(posedge clk_i) cyc <= cyc + 1;

  acc_t cur, rsp, nxt;
  bit   has_cur, has_rsp, w;

  always @(negedge clk_i) begin
    if (core_gnt_o) begin gnt_log.push_back(1'b0); core_gnt_cyc.push_back(cyc); end
    if (dma_gnt_o) gnt_log.push_back(1'b1);
    if (dm_we_o) we_cnt++;
    if (core_rvalid_o) begin core_rsp_n++; core_last_rd = core_rd_o; core_last_err = core_err_o; end
    if (dma_rvalid_o) begin dma_rsp_n++; dma_last_rd = dma_rd_o; dma_last_err = dma_err_o; end

    if (!rst_n_i) begin
      acc_at.delete();
      next_free = 0;
      last_win  = 1'b1;
      m_addr    = 32'h0;
      m_wd      = 32'h0;
      check("reset_ctrl", {core_gnt_o, dma_gnt_o, core_rvalid_o, dma_rvalid_o, core_err_o, dma_err_o, dm_we_o}, 0);
      check("reset_rd", {core_rd_o, dma_rd_o}, 0);
      check("reset_dm_bus", {dm_addr_o, dm_wd_o}, 0);
    end else begin
      has_cur = acc_at.exists(cyc);
      has_rsp = acc_at.exists(cyc - 1);
      if (has_cur) cur = acc_at[cyc];
      if (has_rsp) rsp = acc_at[cyc - 1];
      check("handshake", {core_gnt_o, dma_gnt_o, core_rvalid_o, dma_rvalid_o, dm_we_o},
            {has_cur && !cur.who, has_cur && cur.who, has_rsp && !rsp.who, has_rsp && rsp.who,
             has_cur && cur.we && !cur.err});
      if (has_cur) begin
        m_addr = cur.addr;
        m_wd   = cur.wd;
        if (cur.we && !cur.err) ref_mem[cur.addr[15:2]] = cur.wd;
      end
      check("dm_bus", {dm_addr_o, dm_wd_o}, {m_addr, m_wd});
      if (has_rsp) begin
        if (!rsp.who) check("core_rsp", {core_rd_o, core_err_o}, {rsp.rd, rsp.err});
        else          check("dma_rsp", {dma_rd_o, dma_err_o}, {rsp.rd, rsp.err});
        acc_at.delete(cyc - 1);
      end
      if (cyc >= next_free && (core_req || dma_req)) begin
        if (core_req && dma_req) w = !last_win;
        else                     w = dma_req;
        nxt.who  = w;
        nxt.we   = w ? dma_we : core_we;
        nxt.addr = w ? dma_addr : core_addr;
        nxt.wd   = w ? dma_wd : core_wd;
        nxt.err  = addr_err(nxt.addr);
        nxt.rd   = (nxt.we || nxt.err) ? 32'h0 : ref_mem[nxt.addr[15:2]];
        acc_at[cyc + 1] = nxt;
        last_win  = w;
        next_free = cyc + 2;
      end
    end
  end

  int last_wait;

  // Starts at posedge+1 of an IDLE cycle; returns at posedge+1 of the cycle after gnt.
  task automatic xfer(input bit who, input bit we, input logic [31:0] addr, input logic [31:0] wd);
    int  n;
    bit  got;
    n = 0;
    if (!who) begin core_req = 1; core_we = we; core_addr = addr; core_wd = wd; end
    else      begin dma_req = 1;  dma_we = we;  dma_addr = addr;  dma_wd = wd;  end
    do begin
      @(negedge clk_i);
      n++;
      got = who ? dma_gnt_o : core_gnt_o;
    end while (!got && n < 40);
    check(who ? "dma_gnt_wait" : "core_gnt_wait", got, 1);
    last_wait = n;
    @(posedge clk_i); #1;
    if (!who) core_req = 0; else dma_req = 0;
  endtask

  task automatic to_rsp();
    @(negedge clk_i); #1;
  endtask

  task automatic to_start();
    @(posedge clk_i); #1;
  endtask

  logic [31:0] bnd [6] = '{32'h0000_0FFC, 32'h0000_1000, 32'h0000_1FFC, 32'h0000_2FFC, 32'h0000_3000, 32'h0000_FFFC};

  function automatic logic [31:0] rand_addr();
    logic [31:0] idx;
    idx = 32'($urandom_range(0, 15)) << 2;
    case ($urandom_range(0, 7))
      0, 1, 2: return idx;
      3:       return 32'h2000 + idx;
      4:       return 32'hF000 + idx;
      5:       return bnd[$urandom_range(0, 5)];
      6:       return idx | 32'($urandom_range(1, 3));
      default: return 32'h1000 + idx;
    endcase
  endfunction

  int  we0, rsp0, n, cg, dg, bad, base;
  bit  c_pend, d_pend;
  logic [3:0] order;

  initial begin
    for (int i = 0; i < 16384; i++) begin dm_mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    core_req = 0; core_we = 0; core_addr = 0; core_wd = 0;
    dma_req = 0;  dma_we = 0;  dma_addr = 0;  dma_wd = 0;
    p_core_req = 0; p_core_we = 0; p_core_addr = 0; p_core_wd = 0;
    p_dma_req = 0;  p_dma_we = 0;  p_dma_addr = 0;  p_dma_wd = 0;
    rst_n_i = 1'b1;
    #3 rst_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_vals", {core_gnt_o, dma_gnt_o, core_rvalid_o, dma_rvalid_o, dm_we_o, dm_addr_o}, 0);
    rst_n_i = 1'b1;
    to_start();

    // simultaneous pairs in round-robin mode: core first after reset, then alternate
    gnt_log.delete();
    fork
      xfer(1'b0, 1'b0, 32'h20, 32'h1);
      xfer(1'b1, 1'b0, 32'h24, 32'h2);
    join
    fork
      xfer(1'b0, 1'b0, 32'h20, 32'h3);
      xfer(1'b1, 1'b0, 32'h24, 32'h4);
    join
    check("rr_len", gnt_log.size(), 4);
    if (gnt_log.size() == 4) begin
      order = {gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]};
      check("rr_order", order, 4'b0101);
    end

    // write then read a STATIC word
    we0 = we_cnt;
    xfer(1'b0, 1'b1, 32'h10, 32'h1234_5678);
    check("wr_gnt_latency", last_wait, 2);
    xfer(1'b0, 1'b0, 32'h10, 32'h0);
    to_rsp();
    check("rd_data", core_last_rd, 32'h1234_5678);
    check("rd_err", core_last_err, 0);
    check("wr_we_cycles", we_cnt - we0, 1);
    to_start();

    // misaligned and unmapped writes must not touch memory
    we0 = we_cnt;
    xfer(1'b0, 1'b1, 32'h13, 32'hBAD0_BAD0);
    to_rsp();
    check("mis_err", {core_last_err, core_last_rd}, {1'b1, 32'h0});
    to_start();
    xfer(1'b0, 1'b1, 32'h1010, 32'hBAD1_BAD1);
    to_rsp();
    check("unmap_err", core_last_err, 1);
    to_start();
    xfer(1'b0, 1'b0, 32'h10, 32'h0);
    to_rsp();
    check("neigh_rd", {core_last_err, core_last_rd}, {1'b0, 32'h1234_5678});
    check("err_no_we", we_cnt - we0, 0);
    to_start();
    xfer(1'b0, 1'b0, 32'h1010, 32'h0);
    to_rsp();
    check("unmap_rd", {core_last_err, core_last_rd}, {1'b1, 32'h0});
    to_start();

    // back-to-back reads: one access every 2 cycles
    base = core_gnt_cyc.size();
    for (int i = 0; i < 4; i++) xfer(1'b0, 1'b0, 32'h10 + 32'(i * 4), 32'h0);
    check("b2b_count", core_gnt_cyc.size() - base, 4);
    if (core_gnt_cyc.size() - base == 4)
      for (int i = 1; i < 4; i++) check("b2b_spacing", core_gnt_cyc[base + i] - core_gnt_cyc[base + i - 1], 2);
    to_rsp();
    to_start();

    // reset during ACCESS of a dma write
    xfer(1'b1, 1'b1, 32'h2000, 32'hAAAA_5555);
    to_rsp();
    to_start();
    rsp0 = dma_rsp_n;
    dma_req = 1; dma_we = 1; dma_addr = 32'h2000; dma_wd = 32'hDEAD_BEEF;
    n = 0;
    do begin @(posedge clk_i); #2; n++; end while (!dma_gnt_o && n < 10);
    check("rst_pre_we", dm_we_o, 1);
    rst_n_i = 1'b0;
    #1;
    check("rst_we_drop", dm_we_o, 0);
    dma_req = 0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_no_rvalid", dma_rsp_n - rsp0, 0);
    check("rst_mem_kept", dm_mem[2048], 32'hAAAA_5555);
    rst_n_i = 1'b1;
    gnt_log.delete();
    fork
      xfer(1'b0, 1'b0, 32'h2000, 32'h0);
      xfer(1'b1, 1'b0, 32'h2000, 32'h0);
    join
    check("rst_first_tie", (gnt_log.size() > 0) ? gnt_log[0] : 1'b1, 0);

    // randomized traffic against the scoreboard
    c_pend = 0; d_pend = 0;
    for (int i = 0; i < 400; i++) begin
      to_start();
      if (c_pend && core_gnt_o) c_pend = 0;
      if (d_pend && dma_gnt_o)  d_pend = 0;
      if (!c_pend) begin
        if (i < 360 && $urandom_range(0, 2) != 0) begin
          core_req = 1; core_we = 1'($urandom_range(0, 1)); core_addr = rand_addr(); core_wd = $urandom;
          c_pend = 1;
        end else core_req = 0;
      end
      if (!d_pend) begin
        if (i < 360 && $urandom_range(0, 2) != 0) begin
          dma_req = 1; dma_we = 1'($urandom_range(0, 1)); dma_addr = rand_addr(); dma_wd = $urandom;
          d_pend = 1;
        end else dma_req = 0;
      end
    end
    check("rand_drained", {c_pend, d_pend}, 0);
    core_req = 0; dma_req = 0;
    repeat (3) to_start();

    // fixed core priority: core re-requesting every IDLE starves dma
    p_core_req = 1; p_core_we = 0; p_core_addr = 32'h10;
    p_dma_req = 1;  p_dma_we = 0;  p_dma_addr = 32'h14;
    cg = 0; dg = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      cg += int'(p_core_gnt);
      dg += int'(p_dma_gnt);
    end
    check("prio_core_gnts", cg, 10);
    check("prio_dma_starved", dg, 0);
    to_start();
    p_core_req = 0;
    n = 0;
    do begin @(negedge clk_i); n++; end while (!p_dma_gnt && n < 6);
    check("prio_dma_served", {p_dma_gnt, 8'(n)}, {1'b1, 8'd2});
    to_start();
    p_dma_req = 0;
    repeat (2) to_start();

    bad = 0;
    for (int i = 0; i < 16384; i++) if (dm_mem[i] !== ref_mem[i]) bad++;
    check("mem_image", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
